// File: rtl/scan_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | scan_ctrl: serpentine full-frame scan sequencer (read, push, step)|
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module scan_ctrl #(
  parameter int SIZE       = 4,
  parameter int TURN_STALL = 2
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              abort,
  input  logic [SIZE-1:0]   img_w,
  input  logic [SIZE-1:0]   img_h,
  output logic [SIZE-1:0]   max_x,
  output logic [SIZE-1:0]   max_y,
  output logic              new_trans,
  output logic              update_pos,
  input  logic              pos_end,
  input  logic              pos_next_dir,
  output logic              rd_req,
  input  logic              rd_valid,
  output logic              px_valid,
  input  logic              px_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2*SIZE-1:0] pix_count
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    REQ  = 3'd2,
    WAIT = 3'd3,
    PUSH = 3'd4,
    STEP = 3'd5,
    TURN = 3'd6,
    FIN  = 3'd7
  } state_t;

  localparam int                CW         = (TURN_STALL > 1) ? $clog2(TURN_STALL) : 1;
  localparam logic [CW-1:0]     STALL_LOAD = CW'((TURN_STALL > 0) ? TURN_STALL - 1 : 0);
  localparam logic [CW-1:0]     STALL_ONE  = CW'(1);
  localparam logic [2*SIZE-1:0] PIX_ONE    = (2*SIZE)'(1);

  state_t            state_q, state_d;
  logic [CW-1:0]     stall_q, stall_d;
  logic [SIZE-1:0]   max_x_q, max_x_d;
  logic [SIZE-1:0]   max_y_q, max_y_d;
  logic              err_q, err_d;
  logic [2*SIZE-1:0] pix_count_q, pix_count_d;
  logic              new_trans_q, new_trans_d;
  logic              update_pos_q, update_pos_d;
  logic              rd_req_q, rd_req_d;
  logic              px_valid_q, px_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_comb begin
    state_d     = state_q;
    stall_d     = stall_q;
    max_x_d     = max_x_q;
    max_y_d     = max_y_q;
    err_d       = err_q;
    pix_count_d = pix_count_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if ((img_w != '0) && (img_h != '0)) begin
            max_x_d = img_w;
            max_y_d = img_h;
            err_d   = 1'b0;
            state_d = INIT;
          end else begin
            err_d   = 1'b1;
            state_d = FIN;
          end
        end
      end
      INIT: begin
        pix_count_d = '0;
        state_d     = REQ;
      end
      REQ:  state_d = WAIT;
      WAIT: if (rd_valid) state_d = PUSH;
      PUSH: begin
        if (px_ready) begin
          pix_count_d = pix_count_q + PIX_ONE;
          state_d     = pos_end ? FIN : STEP;
        end
      end
      STEP: begin
        if (pos_next_dir && (TURN_STALL > 0)) begin
          stall_d = STALL_LOAD;
          state_d = TURN;
        end else begin
          state_d = REQ;
        end
      end
      TURN: begin
        if (stall_q == '0) state_d = REQ;
        else               stall_d = stall_q - STALL_ONE;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort discards everything this cycle would have committed, including a start in IDLE.
    if (abort) begin
      state_d     = IDLE;
      stall_d     = stall_q;
      max_x_d     = max_x_q;
      max_y_d     = max_y_q;
      err_d       = err_q;
      pix_count_d = pix_count_q;
    end

    new_trans_d  = (state_d == INIT);
    rd_req_d     = (state_d == REQ);
    px_valid_d   = (state_d == PUSH);
    update_pos_d = (state_d == STEP);
    done_d       = (state_d == FIN);
    busy_d       = (state_d != IDLE) && (state_d != FIN);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      stall_q      <= '0;
      max_x_q      <= '0;
      max_y_q      <= '0;
      err_q        <= 1'b0;
      pix_count_q  <= '0;
      new_trans_q  <= 1'b0;
      update_pos_q <= 1'b0;
      rd_req_q     <= 1'b0;
      px_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      stall_q      <= stall_d;
      max_x_q      <= max_x_d;
      max_y_q      <= max_y_d;
      err_q        <= err_d;
      pix_count_q  <= pix_count_d;
      new_trans_q  <= new_trans_d;
      update_pos_q <= update_pos_d;
      rd_req_q     <= rd_req_d;
      px_valid_q   <= px_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign max_x      = max_x_q;
  assign max_y      = max_y_q;
  assign new_trans  = new_trans_q;
  assign update_pos = update_pos_q;
  assign rd_req     = rd_req_q;
  assign px_valid   = px_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign pix_count  = pix_count_q;

endmodule
`default_nettype wire

// File: tb/tb_scan_ctrl.sv
`default_nettype none
// Directed bench for scan_ctrl with a serpentine position generator, a
// latency-programmable memory responder and a frame-level result queue.
module tb_scan_ctrl;

  localparam int SIZE = 4;
  localparam int TS   = 2;

  logic              clk = 1'b0;
  logic              n_rst = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [SIZE-1:0]   img_w = '0;
  logic [SIZE-1:0]   img_h = '0;
  logic [SIZE-1:0]   max_x, max_y;
  logic              new_trans, update_pos, pos_end, pos_next_dir;
  logic              rd_req;
  logic              rd_valid = 1'b0;
  logic              px_valid;
  logic              px_ready = 1'b1;
  logic              busy, done, err;
  logic [2*SIZE-1:0] pix_count;

  scan_ctrl #(.SIZE(SIZE), .TURN_STALL(TS)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
    .img_w(img_w), .img_h(img_h), .max_x(max_x), .max_y(max_y),
    .new_trans(new_trans), .update_pos(update_pos),
    .pos_end(pos_end), .pos_next_dir(pos_next_dir),
    .rd_req(rd_req), .rd_valid(rd_valid),
    .px_valid(px_valid), .px_ready(px_ready),
    .busy(busy), .done(done), .err(err), .pix_count(pix_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Serpentine position generator
  logic [SIZE-1:0] gx = '0, gy = '0;
  logic            gdir = 1'b0;
  logic            row_end;
  assign row_end      = gdir ? (gx == '0) : (gx == max_x - 4'd1);
  assign pos_next_dir = row_end;
  assign pos_end      = row_end && (gy == max_y - 4'd1);
  always @(posedge clk) begin
    if (new_trans) begin
      gx <= '0; gy <= '0; gdir <= 1'b0;
    end else if (update_pos) begin
      if (row_end) begin
        gy   <= gy + 4'd1;
        gdir <= ~gdir;
      end else begin
        gx <= gdir ? gx - 4'd1 : gx + 4'd1;
      end
    end
  end

  typedef struct {
    int             pix;
    int             cyc;
    logic           err;
    int             nt;
    int             up;
    int             rd;
    logic [SIZE-1:0] mx;
    logic [SIZE-1:0] my;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   t0 = 0;
  int   last_pix = 0;
  logic [SIZE-1:0] last_mx = '0, last_my = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  task automatic start_frame(input logic [SIZE-1:0] w, input logic [SIZE-1:0] h,
                             input int lat, input int stall_len, input bit push);
    exp_t e;
    int   n;
    n     = int'(w) * int'(h);
    e.err = (w == '0) || (h == '0);
    e.cyc = e.err ? 1 : n * (lat + 3) + TS * (int'(h) - 1) + stall_len + 1;
    e.pix = e.err ? last_pix : n;
    e.nt  = e.err ? 0 : 1;
    e.up  = e.err ? 0 : n - 1;
    e.rd  = e.err ? 0 : n;
    e.mx  = e.err ? last_mx : w;
    e.my  = e.err ? last_my : h;
    if (!e.err) begin
      last_pix = n; last_mx = w; last_my = h;
    end
    if (push) sb.push_back(e);
    @(negedge clk);
    img_w = w; img_h = h; start = 1'b1;
    @(posedge clk);
    #1;
    t0    = cyc;
    start = 1'b0;
  endtask

  task automatic run_frame(input int lat, input int stall_pix, input int stall_len,
                           input int abort_pix, input bit mid_start);
    int   cnt = 0, stall_rem = stall_len, ab_k = -1;
    int   n_nt = 0, n_up = 0, n_rd = 0;
    bit   stall_on = 0, fin = 0, prev_rd = 0;
    exp_t e;
    for (int k = 0; k < 400 && !fin; k++) begin
      @(negedge clk);
      if (ab_k >= 0 && k > ab_k) begin
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_pxv", px_valid, 0);
        if (k == ab_k + 1) chk("abort_pix", pix_count, abort_pix - 1);
        if (k >= ab_k + 6) fin = 1;
      end
      if (new_trans)  n_nt++;
      if (update_pos) n_up++;
      if (rd_req)     n_rd++;
      // memory responder: rd_valid lat cycles after rd_req
      rd_valid = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) rd_valid = 1'b1;
      end
      if (rd_req) cnt = lat;
      if (mid_start) begin
        start = (k == 10);
        if (k == 10) begin img_w = 4'd9; img_h = 4'd9; end
      end
      // detector back-pressure on one chosen pixel
      px_ready = 1'b1;
      if (stall_rem > 0 && (stall_on || (px_valid && pix_count == 8'(stall_pix - 1)))) begin
        stall_on = 1;
        chk("stall_pxv", px_valid, 1);
        chk("stall_pix", pix_count, stall_pix - 1);
        px_ready = 1'b0;
        stall_rem--;
      end
      if (abort_pix > 0 && ab_k < 0 && prev_rd && !rd_req && n_rd == abort_pix) begin
        abort = 1'b1;
        ab_k  = k;
      end
      prev_rd = rd_req;
      if (done) begin
        fin = 1;
        chk("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("done_cycle", cyc - t0 + 1, e.cyc);
          chk("pix_count", pix_count, e.pix);
          chk("err", err, e.err);
          chk("busy_fin", busy, 0);
          chk("n_new_trans", n_nt, e.nt);
          chk("n_update_pos", n_up, e.up);
          chk("n_rd_req", n_rd, e.rd);
          chk("max_x", max_x, e.mx);
          chk("max_y", max_y, e.my);
        end
      end
    end
    chk("frame_timeout", fin, 1);
    start = 1'b0; abort = 1'b0; rd_valid = 1'b0; px_ready = 1'b1;
    @(negedge clk);
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_pix", pix_count, 0);
    chk("rst_maxx", max_x, 0);
    chk("rst_maxy", max_y, 0);
    chk("rst_ctl", {new_trans, update_pos, rd_req, px_valid}, 0);
    n_rst = 1'b1;
    @(negedge clk);

    // 4x3 baseline, with an ignored start pulse mid-frame
    start_frame(4'd4, 4'd3, 1, 0, 1);
    run_frame(1, 0, 0, 0, 1);

    // back-pressure on pixel 5 for 3 cycles
    start_frame(4'd4, 4'd3, 1, 3, 1);
    run_frame(1, 5, 3, 0, 0);

    // zero-width start, then a valid 2x2 frame
    start_frame(4'd0, 4'd3, 1, 0, 1);
    run_frame(1, 0, 0, 0, 0);
    start_frame(4'd2, 4'd2, 1, 0, 1);
    run_frame(1, 0, 0, 0, 0);

    // abort in WAIT of pixel 6, late rd_valid lands in IDLE, then full restart
    start_frame(4'd4, 4'd3, 3, 0, 0);
    run_frame(3, 0, 0, 6, 0);
    start_frame(4'd4, 4'd3, 1, 0, 1);
    run_frame(1, 0, 0, 0, 0);

    // 1x1 with read latency 3
    start_frame(4'd1, 4'd1, 3, 0, 1);
    run_frame(3, 0, 0, 0, 0);

    // start together with abort in IDLE is ignored
    img_w = 4'd5; img_h = 4'd5; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", busy, 0);
    chk("sa_new_trans", new_trans, 0);
    chk("sa_done", done, 0);
    chk("sa_maxx", max_x, 1);
    chk("sa_maxy", max_y, 1);
    @(negedge clk);
    chk("sa_busy2", busy, 0);
    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/scan_ctrl.md
Name: scan_ctrl

Overview:
Sequencer for one full-frame serpentine pixel scan in the FAST corner pipeline. Accepts a start command with image dimensions and drives the pixel-position generator (clear, step, dims). Issues one memory read per pixel and hands each returned pixel to the detector over a valid/ready handshake. Inserts a fixed stall at every row turn so the window buffer can shift, then pulses done at end of frame.

Parameters:
SIZE, 4, coordinate width; also width of img_w, img_h, max_x, max_y
TURN_STALL, 2, idle cycles inserted after each row advance (0 = no stall)

Ports:
clk  in  1  clock
n_rst  in  1  reset, asynchronous, active-low
start  in  1  frame start pulse; sampled only in IDLE
abort  in  1  terminate scan; honoured in every state
img_w  in  SIZE  image width in pixels; latched on accepted start
img_h  in  SIZE  image height in pixels; latched on accepted start
max_x  out  SIZE  latched width to position generator
max_y  out  SIZE  latched height to position generator
new_trans  out  1  generator clear pulse (position -> 0,0)
update_pos  out  1  generator step pulse
pos_end  in  1  generator: current position is last pixel
pos_next_dir  in  1  generator: this step advances the row (valid while update_pos=1)
rd_req  out  1  one-cycle read request for current position
rd_valid  in  1  read data returned
px_valid  out  1  pixel available to detector
px_ready  in  1  detector accepts pixel
busy  out  1  scan in progress
done  out  1  one-cycle end-of-frame pulse
err  out  1  sticky: start with zero dimension
pix_count  out  2*SIZE  pixels delivered in current/last frame

Behaviour:
- Reset: state IDLE; all outputs 0, including max_x, max_y, pix_count, err.
- States: IDLE, INIT, REQ, WAIT, PUSH, STEP, TURN, FIN.
- IDLE: start=1 and img_w,img_h both nonzero -> latch dims into max_x/max_y, clear err, go INIT. start=1 with either dimension 0 -> err<=1, done pulses next cycle (via FIN), no generator activity.
- INIT: new_trans=1 for exactly one cycle; pix_count<=0; -> REQ.
- REQ: rd_req=1 for exactly one cycle -> WAIT.
- WAIT: hold until rd_valid=1 -> PUSH. rd_valid in any other state is ignored.
- PUSH: px_valid=1 held until px_ready. On the handshake cycle pix_count increments. If pos_end=1 -> FIN, else -> STEP.
- STEP: update_pos=1 for exactly one cycle. If pos_next_dir=1 and TURN_STALL>0 -> TURN with stall counter loaded TURN_STALL-1, else -> REQ.
- TURN: counter decrements each cycle; at 0 -> REQ. Total TURN cycles = TURN_STALL.
- FIN: done=1 for one cycle -> IDLE.
- busy=1 in INIT, REQ, WAIT, PUSH, STEP, TURN; 0 in IDLE and FIN.
- max_x/max_y stay stable from accept until the next accepted start.
- Minimum pixel period is 4 cycles (REQ, 1-cycle WAIT, PUSH, STEP). The last pixel has no STEP.
- abort=1: go to IDLE on the next edge from any state. No done pulse. pix_count and dims hold. An outstanding rd_valid is dropped.
- abort and start in the same IDLE cycle: abort wins, start is ignored.
- start while busy is ignored.
- 1x1 image: INIT, REQ, WAIT, PUSH, FIN. No update_pos.

Test Plan:
- 4x3 image, TURN_STALL=2, rd_valid 1 cycle after rd_req, px_ready=1, generator model attached -> 1 new_trans, 11 update_pos, 2 TURN stalls of 2 cycles; done in the 53rd cycle after start edge; pix_count=12.
- Same frame with px_ready low 3 cycles on pixel 5 -> px_valid held steady, pix_count unchanged until handshake, done delayed by exactly 3 cycles.
- start with img_w=0, img_h=3 -> err=1, done pulses once, no rd_req/new_trans; then valid 2x2 start -> err clears, pix_count=4.
- abort asserted in WAIT during pixel 6 of 4x3 -> IDLE next cycle, busy=0, no done, pix_count=5; late rd_valid ignored; restart completes a full 12-pixel frame.
- 1x1 image, rd latency 3 cycles -> rd_req once, update_pos never, done 7 cycles after start edge, pix_count=1.
- start pulsed again mid-frame and at the same edge as abort in IDLE -> both ignored; dims unchanged.
